// File: rtl/fb_console_pkg.sv
// fb_console_pkg: shared constants and types for the framebuffer console writer.
//   DEF_COLS / DEF_ROWS / DEF_CLR_CHAR : default geometry and fill byte
//   CC_*                               : recognised control codes
//   state_e                            : writer FSM states
//   cur_cmd_e                          : commands accepted by fb_cursor
package fb_console_pkg;

  localparam int unsigned AW           = 12;
  localparam int unsigned DEF_COLS     = 100;
  localparam int unsigned DEF_ROWS     = 40;
  localparam logic [7:0]  DEF_CLR_CHAR = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_NL,
    CUR_CR,
    CUR_BS,
    CUR_ZERO
  } cur_cmd_e;

endpackage

// File: rtl/fb_cursor.sv
// fb_cursor: text cursor as a linear address plus a column counter (no multiplier).
//   clk50, rst : clock, synchronous active-high reset (cursor -> 0)
//   cmd        : CUR_ADV / CUR_NL / CUR_CR / CUR_BS / CUR_ZERO / CUR_NONE
//   addr       : current linear cursor address row*COLS+col
//   wrap       : the present ADV or NL command reaches COLS*ROWS and wraps to 0
module fb_cursor
  import fb_console_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic          clk50,
  input  logic          rst,
  input  cur_cmd_e      cmd,
  output logic [AW-1:0] addr,
  output logic          wrap
);

  localparam logic [AW:0]   NCELLS   = (AW+1)'(COLS * ROWS);
  localparam logic [AW-1:0] COLS_W   = AW'(COLS);
  localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW:0]   adv_sum, nl_sum;

  always_comb begin
    // One extra bit so the compare against COLS*ROWS also holds at 4096 cells.
    adv_sum = {1'b0, addr_q} + (AW+1)'(1);
    nl_sum  = {1'b0, addr_q} + {1'b0, COLS_W - col_q};
    addr_d  = addr_q;
    col_d   = col_q;
    wrap    = 1'b0;
    case (cmd)
      CUR_ADV: begin
        if (adv_sum == NCELLS) begin
          wrap   = 1'b1;
          addr_d = '0;
          col_d  = '0;
        end else begin
          addr_d = adv_sum[AW-1:0];
          col_d  = (col_q == LAST_COL) ? '0 : col_q + AW'(1);
        end
      end
      CUR_NL: begin
        col_d = '0;
        if (nl_sum == NCELLS) begin
          wrap   = 1'b1;
          addr_d = '0;
        end else begin
          addr_d = nl_sum[AW-1:0];
        end
      end
      CUR_CR: begin
        addr_d = addr_q - col_q;
        col_d  = '0;
      end
      CUR_BS: begin
        if (addr_q != '0) begin
          addr_d = addr_q - AW'(1);
          col_d  = (col_q == '0) ? LAST_COL : col_q - AW'(1);
        end
      end
      CUR_ZERO: begin
        addr_d = '0;
        col_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      addr_q <= '0;
      col_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/fb_console_writer.sv
// fb_console_writer: ASCII byte stream -> framebuffer writes, with cursor and
// hardware screen clear.
//   clk50, rst   : 50 MHz clock, synchronous active-high reset
//   char_data/char_valid/char_ready : incoming byte handshake
//   fb_data/fb_addr/fb_we           : registered framebuffer write port
//   cursor_addr  : linear cursor address
//   busy         : clear sweep in progress
// Optional feature: define FB_CONSOLE_CLEAR_ON_WRAP_EN to clear the screen on
// a screen-end wrap (a wrapping printable byte is then written at 0 after the sweep).
module fb_console_writer
  import fb_console_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter logic [7:0]  CLR_CHAR = DEF_CLR_CHAR
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [7:0]  fb_data,
  output logic [11:0] fb_addr,
  output logic        fb_we,
  output logic [11:0] cursor_addr,
  output logic        busy
);

  localparam logic [AW:0] NCELLS = (AW+1)'(COLS * ROWS);

  state_e        state_q, state_d;
  logic [AW:0]   sweep_q, sweep_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]    fb_data_q, fb_data_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_data_q, pend_data_d;

  cur_cmd_e      cur_cmd;
  logic [AW-1:0] cur_addr;
  logic          cur_wrap;
  logic          accept;
  logic          sweep_done;
  logic          start_clear;

  assign char_ready = (state_q == ST_IDLE) && !rst;
  assign accept     = char_valid && char_ready;
  assign sweep_done = (sweep_q >= NCELLS);

  fb_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk50(clk50),
    .rst  (rst),
    .cmd  (cur_cmd),
    .addr (cur_addr),
    .wrap (cur_wrap)
  );

`ifndef FB_CONSOLE_CLEAR_ON_WRAP_EN
  logic unused_wrap;
  assign unused_wrap = cur_wrap;
`endif

  // Cursor command decode kept apart from the write logic: the write logic
  // reads cur_wrap, which is itself a function of cur_cmd.
  always_comb begin
    cur_cmd = CUR_NONE;
    case (state_q)
      ST_CLEAR: begin
        if (sweep_done) cur_cmd = pend_q ? CUR_ADV : CUR_ZERO;
      end
      ST_IDLE: begin
        if (accept) begin
          case (char_data)
            CC_FF:   cur_cmd = CUR_NONE;
            CC_LF:   cur_cmd = CUR_NL;
            CC_CR:   cur_cmd = CUR_CR;
            CC_BS:   cur_cmd = (cur_addr != '0) ? CUR_BS : CUR_NONE;
            default: cur_cmd = CUR_ADV;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    start_clear = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (!sweep_done) begin
          fb_we_d   = 1'b1;
          fb_addr_d = sweep_q[AW-1:0];
          fb_data_d = CLR_CHAR;
          sweep_d   = sweep_q + (AW+1)'(1);
        end else begin
          state_d = ST_IDLE;
          // A held-back wrapping byte lands at the (already zeroed) cursor.
          if (pend_q) begin
            fb_we_d   = 1'b1;
            fb_addr_d = cur_addr;
            fb_data_d = pend_data_q;
            pend_d    = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (char_data)
            CC_FF: start_clear = 1'b1;
            CC_LF: begin
`ifdef FB_CONSOLE_CLEAR_ON_WRAP_EN
              if (cur_wrap) start_clear = 1'b1;
`endif
            end
            CC_CR: ;
            CC_BS: begin
              if (cur_addr != '0) begin
                fb_we_d   = 1'b1;
                fb_addr_d = cur_addr - AW'(1);
                fb_data_d = CLR_CHAR;
              end
            end
            default: begin
`ifdef FB_CONSOLE_CLEAR_ON_WRAP_EN
              if (cur_wrap) begin
                start_clear = 1'b1;
                pend_d      = 1'b1;
                pend_data_d = char_data;
              end else begin
                fb_we_d   = 1'b1;
                fb_addr_d = cur_addr;
                fb_data_d = char_data;
              end
`else
              fb_we_d   = 1'b1;
              fb_addr_d = cur_addr;
              fb_data_d = char_data;
`endif
            end
          endcase
        end
      end
      default: ;
    endcase
    // Entering a clear from IDLE issues address 0 immediately, so the sweep
    // proper continues from 1 and still totals COLS*ROWS writes.
    if (start_clear) begin
      state_d   = ST_CLEAR;
      fb_we_d   = 1'b1;
      fb_addr_d = '0;
      fb_data_d = CLR_CHAR;
      sweep_d   = (AW+1)'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign cursor_addr = cur_addr;
  assign busy        = (state_q == ST_CLEAR);

endmodule
